// File: rtl/score_ctrl_pkg.sv
// Shared definitions for the scoreboard button sequencer: FSM state
// encoding, direction encoding and small elaboration-time helpers.
package score_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR      = 3'd1,
        ST_FIRE     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;
    localparam int   DEF_MAX_VAL = 99;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/score_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced
// level only follows the synchronised input after it has differed from the
// current level for DEB_CYC consecutive cycles; any glitch restarts the count.
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic db_o
);

    localparam int CW = $clog2(DEB_CYC);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_i;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive cycles of disagreement; flip the level on the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (r_s2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEB_CYC - 1)) begin
            r_cnt <= '0;
            r_db  <= r_s2;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign db_o = r_db;

endmodule

// File: rtl/score_ctrl.sv
// Button front-end for the score counter: debounces up/down/clear, arbitrates
// between them and issues single-cycle strobes with auto-repeat, suppressing
// requests that would push the counter past 0 or MAX_VAL.
module score_ctrl
    import score_ctrl_pkg::*;
#(
    parameter int BW      = 7,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int DEB_CYC = 16,
    parameter int REP_DLY = 2000,
    parameter int REP_PER = 500
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          btn_up_i,
    input  logic          btn_down_i,
    input  logic          btn_clr_i,
    input  logic [BW-1:0] counter_val_i,
    output logic          cnt_up_o,
    output logic          cnt_down_o,
    output logic          cnt_clr_o,
    output logic          limit_o,
    output logic          busy_o
);

    localparam int            TW     = $clog2(max_int(REP_DLY, REP_PER)) + 1;
    // The timer is loaded as FIRE is left and FIRE is re-entered one cycle
    // after it reaches zero, so the load value is the period minus two.
    localparam logic [TW-1:0] DLY_LD = TW'(REP_DLY - 2);
    localparam logic [TW-1:0] PER_LD = TW'(REP_PER - 2);
    localparam logic [BW-1:0] MAX_V  = BW'(MAX_VAL);

    logic          w_db_up;
    logic          w_db_down;
    logic          w_db_clr;
    state_t        r_state;
    state_t        w_next;
    logic          r_dir;
    logic          r_rep;
    logic [TW-1:0] r_timer;
    logic          w_dir_btn;
    logic          w_opp_btn;
    logic          w_dir_nxt;
    logic          w_can;
    logic          w_up;
    logic          w_down;
    logic          w_clr;
    logic          w_limit;
    logic          r_up;
    logic          r_down;
    logic          r_clr;
    logic          r_limit;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_db_up (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_up_i),   .db_o(w_db_up)
    );
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_db_down (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_down_i), .db_o(w_db_down)
    );
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_db_clr (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_clr_i),  .db_o(w_db_clr)
    );

    assign w_dir_btn = (r_dir == DIR_UP) ? w_db_up   : w_db_down;
    assign w_opp_btn = (r_dir == DIR_UP) ? w_db_down : w_db_up;

    // State register plus the direction latch, which tracks up/down while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_DOWN;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) r_dir <= w_dir_nxt;
        end
    end

    // Next-state: clr has priority, a lone up/down fires, both together wait.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_db_clr)                  w_next = ST_CLR;
                else if (w_db_up ^ w_db_down)  w_next = ST_FIRE;
                else if (w_db_up & w_db_down)  w_next = ST_WAIT_REL;
            end
            ST_CLR:  w_next = ST_WAIT_REL;
            ST_FIRE: w_next = ST_HOLD;
            ST_HOLD: begin
                if (!w_dir_btn)                w_next = ST_IDLE;
                else if (w_db_clr | w_opp_btn) w_next = ST_WAIT_REL;
                else if (r_timer == '0)        w_next = ST_FIRE;
            end
            ST_WAIT_REL: begin
                if (!(w_db_up | w_db_down | w_db_clr)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so the registered strobe lines up
    // with the FIRE/CLR cycle; the limit check uses the live counter value.
    always_comb begin
        w_dir_nxt = (r_state == ST_IDLE) ? (w_db_up ? DIR_UP : DIR_DOWN) : r_dir;
        w_can     = (w_dir_nxt == DIR_UP) ? (counter_val_i < MAX_V)
                                          : (counter_val_i != '0);
        w_up      = (w_next == ST_FIRE) && (w_dir_nxt == DIR_UP)   && w_can;
        w_down    = (w_next == ST_FIRE) && (w_dir_nxt == DIR_DOWN) && w_can;
        w_limit   = (w_next == ST_FIRE) && !w_can;
        w_clr     = (w_next == ST_CLR);
    end

    // Repeat timer: first FIRE of a press loads the long delay, later ones the period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer <= '0;
            r_rep   <= 1'b0;
        end else if (r_state == ST_FIRE) begin
            r_timer <= r_rep ? PER_LD : DLY_LD;
            r_rep   <= 1'b1;
        end else begin
            if (r_state == ST_IDLE) r_rep <= 1'b0;
            if (r_state == ST_HOLD && r_timer != '0) r_timer <= r_timer - TW'(1);
        end
    end

    // Output registers; cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_clr   <= 1'b0;
            r_limit <= 1'b0;
        end else begin
            r_up    <= w_up;
            r_down  <= w_down;
            r_clr   <= w_clr;
            r_limit <= w_limit;
        end
    end

    assign cnt_up_o   = r_up;
    assign cnt_down_o = r_down;
    assign cnt_clr_o  = r_clr;
    assign limit_o    = r_limit;
    assign busy_o     = (r_state != ST_IDLE);

endmodule
